// File: rtl/TauCfg.sv
// ============================================================================
// Package     : TauCfg
// Description : Shared sizing defaults for the tau block pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package TauCfg;
  localparam int WORK_BW           = 16;
  localparam int VDIM              = 4;
  localparam int MAX_PENDING_BLOCK = 4;
endpackage

`default_nettype wire

// File: rtl/block_ofs_receiver.sv
// ============================================================================
// Module      : block_ofs_receiver
// Description : Queues block offsets from the looper, hands them to the core
//               in order and reports one done pulse per finished block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_ofs_receiver #(
  parameter int WBW       = TauCfg::WORK_BW,
  parameter int VDIM      = TauCfg::VDIM,
  parameter int N_PENDING = TauCfg::MAX_PENDING_BLOCK
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               bofs_rdy,
  output logic                               bofs_ack,
  input  logic [VDIM-1:0][WBW-1:0]           i_bofs,
  output logic                               dst_rdy,
  input  logic                               dst_ack,
  output logic [VDIM-1:0][WBW-1:0]           o_bofs,
  input  logic                               i_core_done,
  output logic                               o_blkdone_dval,
  output logic [$clog2(N_PENDING+1)-1:0]     o_n_inflight,
  output logic                               o_idle,
  output logic                               o_err
);

  localparam int CW = $clog2(N_PENDING + 1);
  localparam int PW = $clog2(N_PENDING);

  localparam logic [CW-1:0] c_n_pending = CW'(N_PENDING);
  localparam logic [CW-1:0] c_one       = CW'(1);
  localparam logic [PW-1:0] c_last_ptr  = PW'(N_PENDING - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [VDIM-1:0][WBW-1:0]  r_mem [N_PENDING];
  logic [VDIM-1:0][WBW-1:0]  r_head;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_queued;
  logic [CW-1:0]             r_dispatched;
  logic                      r_blkdone;
  logic                      r_err;

  logic                      w_enq;
  logic                      w_deq;
  logic                      w_done_ok;
  logic [CW-1:0]             w_inflight;
  logic [CW-1:0]             w_queued_next;
  logic [CW-1:0]             w_disp_next;
  logic [PW-1:0]             w_rd_next;
  logic [VDIM-1:0][WBW-1:0]  w_head_next;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Full check looks only at the current counts, so a same-cycle dispatch never frees a slot.
  assign w_inflight = r_queued + r_dispatched;
  assign w_enq      = bofs_rdy && !i_rst && (r_queued < c_n_pending) && (w_inflight < c_n_pending);
  assign w_deq      = dst_ack && dst_rdy;
  assign w_done_ok  = i_core_done && (r_dispatched != '0);

  assign w_queued_next = r_queued + (w_enq ? c_one : '0) - (w_deq ? c_one : '0);
  assign w_disp_next   = r_dispatched + (w_deq ? c_one : '0) - (w_done_ok ? c_one : '0);
  assign w_rd_next     = w_deq ? f_inc(r_rd_ptr) : r_rd_ptr;

  // A write landing on the next head slot only happens when it becomes the sole queued entry.
  assign w_head_next = (w_enq && (r_wr_ptr == w_rd_next)) ? i_bofs : r_mem[w_rd_next];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_queued     <= '0;
      r_dispatched <= '0;
      r_head       <= '0;
      r_blkdone    <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < N_PENDING; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= i_bofs;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      r_rd_ptr     <= w_rd_next;
      r_queued     <= w_queued_next;
      r_dispatched <= w_disp_next;
      r_head       <= w_head_next;
      r_blkdone    <= w_done_ok;
      if (i_core_done && (r_dispatched == '0)) begin
        r_err <= 1'b1;
      end
      if (w_queued_next != '0) begin
        r_state <= S_ACTIVE;
      end else if (w_disp_next != '0) begin
        r_state <= S_DRAIN;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign bofs_ack       = w_enq;
  assign dst_rdy        = (r_state == S_ACTIVE);
  assign o_bofs         = r_head;
  assign o_blkdone_dval = r_blkdone;
  assign o_n_inflight   = w_inflight;
  assign o_idle         = (w_inflight == '0);
  assign o_err          = r_err;

endmodule

`default_nettype wire

// File: doc/block_ofs_receiver.md
BLOCK_OFS_RECEIVER -- requirements
Module: block_ofs_receiver

Interface
REQ-001 Parameters SHALL be: WBW, default TauCfg::WORK_BW, offset word width; VDIM, default TauCfg::VDIM, offset dimensions; N_PENDING, default TauCfg::MAX_PENDING_BLOCK, queue depth (>=2, need not be a power of 2).
REQ-002 Ports SHALL be, with clock and reset first:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, asynchronous, active-high.
- bofs_rdy  in  1  block offset offered by the looper.
- bofs_ack  out  1  offset accepted.
- i_bofs  in  WBW x VDIM  block offset.
- dst_rdy  out  1  block offset presented to the core pipeline.
- dst_ack  in  1  core takes the offset; legal only while dst_rdy is high.
- o_bofs  out  WBW x VDIM  offset at the queue head.
- i_core_done  in  1  single-cycle pulse, oldest dispatched block finished.
- o_blkdone_dval  out  1  single-cycle pulse to the looper, one per finished block.
- o_n_inflight  out  $clog2(N_PENDING+1)  queued plus dispatched-not-done count.
- o_idle  out  1  inflight count is zero.
- o_err  out  1  sticky protocol-error flag.

Function
REQ-003 bofs_ack SHALL be combinational: bofs_rdy && (queued count < N_PENDING) && (inflight count < N_PENDING).
REQ-004 The full check SHALL use the current-cycle count only; a simultaneous dst_ack SHALL NOT free a slot for the same cycle (no bypass).
REQ-005 On bofs_ack, i_bofs SHALL be written at the write pointer, and the write pointer SHALL advance, wrapping from N_PENDING-1 to 0.
REQ-006 dst_rdy SHALL equal (queued count != 0), driven from registered state.
- Minimum latency from bofs_ack to dst_rdy is 1 cycle.
- o_bofs SHALL be the registered head entry, stable while dst_rdy is high and dst_ack is low.
REQ-007 On dst_ack, the read pointer SHALL advance with the same wrap rule, queued count SHALL decrement, and dispatched count SHALL increment.
REQ-008 Counter updates on each clock edge:
- queued count: +bofs_ack, -dst_ack.
- dispatched count: +dst_ack, -i_core_done.
- Any combination of bofs_ack, dst_ack and i_core_done in the same cycle SHALL be applied together, with no event lost.
REQ-009 o_n_inflight SHALL equal queued + dispatched; o_idle SHALL equal (o_n_inflight == 0).
REQ-010 o_blkdone_dval SHALL be the registered i_core_done, one cycle later, when the dispatched count is nonzero.
REQ-011 i_core_done while the dispatched count is 0 SHALL set o_err, SHALL produce no o_blkdone_dval, and SHALL leave the counters unchanged.
REQ-012 bofs_rdy high with the queue full SHALL NOT be an error; bofs_ack simply stays low.
REQ-013 Control state machine:
- IDLE: inflight = 0, dst_rdy low.
- ACTIVE: queued > 0.
- DRAIN: queued = 0, dispatched > 0.
- Transitions follow the counter values after each edge; IDLE to ACTIVE on bofs_ack; DRAIN to ACTIVE on bofs_ack; ACTIVE to DRAIN when the last queued entry is acked; DRAIN to IDLE on the final done.
REQ-014 o_err SHALL be cleared only by reset.

Reset
REQ-015 Asserting i_rst at any time SHALL asynchronously force:
- pointers, counters and state to IDLE/0;
- bofs_ack=0, dst_rdy=0, o_blkdone_dval=0, o_err=0, o_idle=1, o_n_inflight=0;
- all o_bofs words to 0.
REQ-016 Queued and dispatched blocks in flight at reset SHALL be discarded without generating done pulses.
REQ-017 The first bofs_ack SHALL be possible in the first cycle after i_rst deasserts.

Verification
Bench parameters: WBW=16, VDIM=4, N_PENDING=3.
REQ-018 Single block: offer {1,2,3,4}; dst_ack held high -> bofs_ack at cycle 0; dst_rdy at cycle 1 with o_bofs={1,2,3,4}; i_core_done at cycle 5 -> o_blkdone_dval at cycle 6, o_idle=1 at cycle 6.
REQ-019 Full queue: offer 4 offsets with dst_ack held low -> 3 acks; 4th bofs_rdy stalls. One dst_ack, then one i_core_done -> 4th acked the cycle after the done. No ack occurs in the dst_ack-only cycle, because inflight is still 3.
REQ-020 Wrap-around: stream 10 offsets {k,0,0,0}, k=0..9, with random dst_ack and i_core_done -> dispatch order 0..9, exactly 10 o_blkdone_dval pulses, final o_n_inflight=0.
REQ-021 Simultaneous events: in a single cycle, bofs_ack, dst_ack and i_core_done with queued=1 and dispatched=1 -> queued=1, dispatched=1, one done pulse.
REQ-022 Error and reset: i_core_done while idle -> o_err=1 and no done pulse. Then i_rst mid-stream with 2 queued -> all outputs at reset values, o_err=0, no done pulses.
